gx_std_x2_rst_ctrl: RTL

Reset sequencer for the 2-channel bonded standard-PCS transceiver. One shared TX sequence drives both channels, because TX is bonded to a common PLL. Each RX channel has its own independent sequence. The block orders analog and digital resets against PLL lock, calibration-busy and CDR lock-to-data, and reports per-direction ready to the GBT link logic.

---
 rtl/gx_std_x2_rst_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/gx_std_x2_rst_ctrl.sv
// Reset sequencer for the 2-channel bonded standard-PCS transceiver.
// Shared TX sequence, independent per-channel RX sequences.
`timescale 1ns/1ps
module gx_std_x2_rst_ctrl #(
  parameter int NUM_CH   = 2,
  parameter int T_ANALOG = 70,
  parameter int T_TX_DIG = 20,
  parameter int T_LTD    = 400
) (
  input  logic              reconfig_clk,
  input  logic              reconfig_reset,
  input  logic              pll_locked,
  input  logic [NUM_CH-1:0] tx_cal_busy,
  input  logic [NUM_CH-1:0] rx_cal_busy,
  input  logic [NUM_CH-1:0] rx_is_lockedtodata,
  input  logic              tx_reset_req,
  input  logic [NUM_CH-1:0] rx_reset_req,
  output logic [NUM_CH-1:0] tx_analogreset,
  output logic [NUM_CH-1:0] tx_digitalreset,
  output logic [NUM_CH-1:0] rx_analogreset,
  output logic [NUM_CH-1:0] rx_digitalreset,
  output logic              tx_ready,
  output logic [NUM_CH-1:0] rx_ready
);

  localparam int TM1  = (T_ANALOG > T_TX_DIG) ? T_ANALOG : T_TX_DIG;
  localparam int TMAX = (TM1 > T_LTD) ? TM1 : T_LTD;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] ANA_END = CW'(T_ANALOG - 1);
  localparam logic [CW-1:0] DIG_END = CW'(T_TX_DIG - 1);
  localparam logic [CW-1:0] LTD_END = CW'(T_LTD - 1);

  typedef enum logic [1:0] {
    TX_ANA, TX_WAIT, TX_DIG, TX_READY
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_ANA, RX_WAIT_CAL, RX_WAIT_LTD, RX_READY
  } rx_state_t;

  function automatic logic [CW-1:0] sat_inc(
    input logic [CW-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

  // Cal-busy syncs reset to busy so nothing advances on stale state.
  logic              pll_s1, pll_s;
  logic [NUM_CH-1:0] txc_s1, txc_s;
  logic [NUM_CH-1:0] rxc_s1, rxc_s;
  logic [NUM_CH-1:0] ltd_s1, ltd_s;

  always_ff @(posedge reconfig_clk or posedge reconfig_reset) begin
    if (reconfig_reset) begin
      pll_s1 <= 1'b0;
      pll_s  <= 1'b0;
      txc_s1 <= '1;
      txc_s  <= '1;
      rxc_s1 <= '1;
      rxc_s  <= '1;
      ltd_s1 <= '0;
      ltd_s  <= '0;
    end else begin
      pll_s1 <= pll_locked;
      pll_s  <= pll_s1;
      txc_s1 <= tx_cal_busy;
      txc_s  <= txc_s1;
      rxc_s1 <= rx_cal_busy;
      rxc_s  <= rxc_s1;
      ltd_s1 <= rx_is_lockedtodata;
      ltd_s  <= ltd_s1;
    end
  end

  tx_state_t         tx_st;
  logic [CW-1:0]     tx_cnt;
  logic              tx_ana, tx_dig;

  always_ff @(posedge reconfig_clk or posedge reconfig_reset) begin
    if (reconfig_reset) begin
      tx_st    <= TX_ANA;
      tx_cnt   <= '0;
      tx_ana   <= 1'b1;
      tx_dig   <= 1'b1;
      tx_ready <= 1'b0;
    end else if (tx_reset_req) begin
      tx_st    <= TX_ANA;
      tx_cnt   <= '0;
      tx_ana   <= 1'b1;
      tx_dig   <= 1'b1;
      tx_ready <= 1'b0;
    end else begin
      unique case (tx_st)
        TX_ANA: begin
          if (tx_cnt == ANA_END) begin
            tx_st  <= TX_WAIT;
            tx_cnt <= '0;
          end else begin
            tx_cnt <= sat_inc(tx_cnt);
          end
        end
        TX_WAIT: begin
          if (pll_s && !(|txc_s)) begin
            tx_st  <= TX_DIG;
            tx_cnt <= '0;
            tx_ana <= 1'b0;
          end
        end
        TX_DIG: begin
          if (!pll_s) begin
            tx_cnt <= '0;
          end else if (tx_cnt == DIG_END) begin
            tx_st    <= TX_READY;
            tx_cnt   <= '0;
            tx_dig   <= 1'b0;
            tx_ready <= 1'b1;
          end else begin
            tx_cnt <= sat_inc(tx_cnt);
          end
        end
        TX_READY: begin
          if (!pll_s) begin
            tx_st    <= TX_DIG;
            tx_cnt   <= '0;
            tx_dig   <= 1'b1;
            tx_ready <= 1'b0;
          end
        end
        default: tx_st <= TX_ANA;
      endcase
    end
  end

  assign tx_analogreset  = {NUM_CH{tx_ana}};
  assign tx_digitalreset = {NUM_CH{tx_dig}};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_rx
    rx_state_t     st;
    logic [CW-1:0] cnt;
    logic          ana, dig, rdy;

    always_ff @(posedge reconfig_clk or posedge reconfig_reset) begin
      if (reconfig_reset) begin
        st  <= RX_ANA;
        cnt <= '0;
        ana <= 1'b1;
        dig <= 1'b1;
        rdy <= 1'b0;
      end else if (rx_reset_req[ch]) begin
        st  <= RX_ANA;
        cnt <= '0;
        ana <= 1'b1;
        dig <= 1'b1;
        rdy <= 1'b0;
      end else begin
        unique case (st)
          RX_ANA: begin
            if (cnt == ANA_END) begin
              st  <= RX_WAIT_CAL;
              cnt <= '0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          RX_WAIT_CAL: begin
            if (!rxc_s[ch]) begin
              st  <= RX_WAIT_LTD;
              cnt <= '0;
              ana <= 1'b0;
            end
          end
          RX_WAIT_LTD: begin
            if (!ltd_s[ch]) begin
              cnt <= '0;
            end else if (cnt == LTD_END) begin
              st  <= RX_READY;
              cnt <= '0;
              dig <= 1'b0;
              rdy <= 1'b1;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          RX_READY: begin
            if (!ltd_s[ch]) begin
              st  <= RX_WAIT_LTD;
              cnt <= '0;
              dig <= 1'b1;
              rdy <= 1'b0;
            end
          end
          default: st <= RX_ANA;
        endcase
      end
    end

    assign rx_analogreset[ch]  = ana;
    assign rx_digitalreset[ch] = dig;
    assign rx_ready[ch]        = rdy;
  end

endmodule
